// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// pwm_duty_ctrl : debounced up/down duty step (0..10) driving PWM and HEX codes
// Revision 1.0
// ============================================================================
module pwm_duty_ctrl #(
    parameter int PRESCALE        = 500,
    parameter int PWM_STEPS       = 100,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int INIT_STEP       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    output logic       pwm_out,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] duty_step
);

    localparam int               c_pre_w     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int               c_db_w      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
    localparam logic [c_db_w-1:0]  c_db_last  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]       c_pwm_last  = 7'(PWM_STEPS - 1);
    localparam logic [3:0]       c_max_step  = 4'd10;
    localparam logic [3:0]       c_init_step = 4'(INIT_STEP);

    logic [1:0] w_btn_raw;
    logic [1:0] w_press;

    assign w_btn_raw = {btn_down_n, btn_up_n};

    // Bit 0 is the up button, bit 1 the down button.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic              sync1_q, sync1_d;
        logic              sync2_q, sync2_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic [c_db_w-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d = w_btn_raw[gi];
            sync2_d = sync1_q;
            level_d = level_q;
            cnt_d   = '0;
            if (sync2_q != level_q) begin
                if (cnt_q == c_db_last) begin
                    level_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            press_d = level_q & ~level_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                level_q <= 1'b1;
                press_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= sync1_d;
                sync2_q <= sync2_d;
                level_q <= level_d;
                press_q <= press_d;
                cnt_q   <= cnt_d;
            end
        end

        assign w_press[gi] = press_q;
    end

    logic [3:0]         step_q, step_d;
    logic [3:0]         active_step_q, active_step_d;
    logic [c_pre_w-1:0] pre_cnt_q, pre_cnt_d;
    logic [6:0]         pwm_cnt_q, pwm_cnt_d;
    logic               pwm_out_q, pwm_out_d;
    logic               w_tick;
    logic               w_wrap;
    logic [6:0]         w_thresh;

    always_comb begin
        step_d = step_q;
        case (w_press)
            2'b01:   if (step_q != c_max_step) step_d = step_q + 4'd1;
            2'b10:   if (step_q != 4'd0)       step_d = step_q - 4'd1;
            default: step_d = step_q;
        endcase
    end

    assign w_tick = (pre_cnt_q == c_pre_last);
    assign w_wrap = w_tick && (pwm_cnt_q == c_pwm_last);

    // Output is computed from next-state values so pwm_out lines up with pwm_cnt_q.
    always_comb begin
        pre_cnt_d     = w_tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d     = pwm_cnt_q;
        active_step_d = active_step_q;
        if (w_tick) begin
            pwm_cnt_d = w_wrap ? 7'd0 : pwm_cnt_q + 7'd1;
        end
        if (w_wrap) begin
            active_step_d = step_q;
        end
        w_thresh  = {3'b000, active_step_d} * 7'd10;
        pwm_out_d = (pwm_cnt_d < w_thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q        <= c_init_step;
            active_step_q <= c_init_step;
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            pwm_out_q     <= 1'b0;
        end else begin
            step_q        <= step_d;
            active_step_q <= active_step_d;
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pwm_out_q     <= pwm_out_d;
        end
    end

    assign pwm_out   = pwm_out_q;
    assign digit0    = step_q;
    assign digit1    = step_q;
    assign digit2    = step_q;
    assign duty_step = step_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pwm_duty_ctrl : scoreboard bench for pwm_duty_ctrl
// Revision 1.0
// ============================================================================
module tb_pwm_duty_ctrl;

    localparam int c_prescale  = 1;
    localparam int c_debounce  = 4;
    localparam int c_init_step = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up_n = 1'b1;
    logic       btn_down_n = 1'b1;
    logic       pwm_out;
    logic [3:0] digit0, digit1, digit2, duty_step;

    int n_checks = 0;
    int n_pass   = 0;
    int model_step;
    int exp_q[$];
    int ncyc;

    pwm_duty_ctrl #(
        .PRESCALE        (c_prescale),
        .PWM_STEPS       (100),
        .DEBOUNCE_CYCLES (c_debounce),
        .INIT_STEP       (c_init_step)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_up_n   (btn_up_n),
        .btn_down_n (btn_down_n),
        .pwm_out    (pwm_out),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .duty_step  (duty_step)
    );

    always #5 clk = ~clk;

    // With PRESCALE=1 the PWM phase is the number of clock edges since reset release, mod 100.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    function automatic int pop_exp();
        return (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input bit dn, input int low_cyc);
        @(negedge clk);
        btn_up_n   = ~up;
        btn_down_n = ~dn;
        cycles(low_cyc);
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        cycles(12);
        if (up && !dn && model_step < 10)      model_step++;
        else if (dn && !up && model_step > 0)  model_step--;
        exp_q.push_back(model_step);
    endtask

    task automatic check_step(input string tag);
        int e;
        e = pop_exp();
        check_val({tag, "_step"}, int'(duty_step), e);
        check_val({tag, "_d0"},   int'(digit0),    e);
        check_val({tag, "_d1"},   int'(digit1),    e);
        check_val({tag, "_d2"},   int'(digit2),    e);
    endtask

    task automatic wait_period_start();
        int k = 0;
        while ((ncyc % 100) != 0 && k < 250) begin
            @(negedge clk);
            k++;
        end
        if (k >= 250) check_val("period_wait_timeout", k, 0);
    endtask

    task automatic measure_period(input string tag);
        int hi = 0;
        wait_period_start();
        for (int i = 0; i < 100; i++) begin
            hi += int'(pwm_out);
            @(negedge clk);
        end
        check_val(tag, hi, pop_exp());
    endtask

    initial begin
        int hi0, hi1, trk;
        model_step = c_init_step;

        // Reset with buttons chattering
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_up_n   = i[0];
            btn_down_n = ~i[0];
        end
        exp_q.push_back(model_step);
        check_step("reset");
        exp_q.push_back(0);
        check_val("reset_pwm", int'(pwm_out), pop_exp());
        btn_up_n   = 1'b1;
        btn_down_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        hi0 = 0;
        for (int i = 0; i < 300; i++) begin
            hi0 += int'(pwm_out);
            @(negedge clk);
        end
        exp_q.push_back(0);
        check_val("idle_pwm", hi0, pop_exp());

        // Single press
        press(1'b1, 1'b0, 10);
        check_step("single");
        exp_q.push_back(model_step * 10);
        measure_period("single_period");

        // Bounce rejection
        repeat (5) begin
            btn_up_n = 1'b0;
            cycles(3);
            btn_up_n = 1'b1;
            cycles(2);
        end
        cycles(10);
        exp_q.push_back(model_step);
        check_step("bounce");
        press(1'b1, 1'b0, 10);
        check_step("after_bounce");

        // Saturation both ways
        repeat (12) begin
            press(1'b1, 1'b0, 10);
            check_step("sat_up");
        end
        exp_q.push_back(100);
        measure_period("sat_hi_period");
        repeat (12) begin
            press(1'b0, 1'b1, 10);
            check_step("sat_dn");
        end
        exp_q.push_back(0);
        measure_period("sat_lo_period");

        // Shadow timing: change mid-period only takes effect at the next boundary
        repeat (3) begin
            press(1'b1, 1'b0, 10);
            check_step("to3");
        end
        exp_q.push_back(30);
        measure_period("shadow_pre");
        hi0 = 0; hi1 = 0; trk = 0;
        for (int i = 0; i < 200; i++) begin
            if (i < 100) hi0 += int'(pwm_out);
            else         hi1 += int'(pwm_out);
            if (digit0 != duty_step || digit1 != duty_step || digit2 != duty_step) trk++;
            if (i == 50) btn_up_n = 1'b0;
            if (i == 60) btn_up_n = 1'b1;
            @(negedge clk);
        end
        model_step++;
        exp_q.push_back(30);
        exp_q.push_back(40);
        check_val("shadow_cur_period", hi0, pop_exp());
        check_val("shadow_next_period", hi1, pop_exp());
        check_val("digit_track", trk, 0);
        exp_q.push_back(model_step);
        check_step("shadow");

        // Simultaneous presses
        press(1'b1, 1'b0, 10);
        check_step("to5");
        press(1'b1, 1'b1, 10);
        check_step("both");

        // Asynchronous reset mid-period
        repeat (2) begin
            press(1'b1, 1'b0, 10);
            check_step("to7");
        end
        exp_q.push_back(70);
        measure_period("step7_period");
        cycles(40);
        exp_q.push_back(1);
        check_val("mid_pwm_high", int'(pwm_out), pop_exp());
        #1 rst_n = 1'b0;
        #1;
        model_step = c_init_step;
        exp_q.push_back(0);
        check_val("async_rst_pwm", int'(pwm_out), pop_exp());
        exp_q.push_back(model_step);
        check_step("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        press(1'b1, 1'b0, 10);
        check_step("post_rst");
        exp_q.push_back(10);
        measure_period("post_rst_period");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
